// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : button_event_decoder
//  Purpose  : Synchronise, debounce and decode raw push-button pins into
//             level, press, release and long-press events, one channel each.
//  Revision : 1.0  initial release
// ============================================================================
module button_event_decoder #(
  parameter int NUM_BTN         = 2,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);

  localparam int DC_W = $clog2(DEBOUNCE_CYCLES);
  localparam int HC_W = $clog2(LONG_CYCLES) + 1;

  localparam logic [DC_W-1:0] c_DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] c_HC_FIRE = HC_W'(LONG_CYCLES - 1);
  localparam logic [HC_W-1:0] c_HC_SAT  = HC_W'(LONG_CYCLES);

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      logic            r_s1;
      logic            r_s2;
      logic            r_st;
      logic [DC_W-1:0] r_dc;
      logic [HC_W-1:0] r_hc;
      logic            r_level;
      logic            r_press;
      logic            r_release;
      logic            r_long;
      logic            w_p;
      logic            w_rise;
      logic            w_fall;

      assign w_p    = btn_raw[i] ^ ACTIVE_LOW;
      // r_level lags r_st by one edge, so a mismatch marks the accepted change
      assign w_rise = r_st & ~r_level;
      assign w_fall = ~r_st & r_level;

      // Synchroniser is deliberately left without reset
      always_ff @(posedge clk) begin
        r_s1 <= w_p;
        r_s2 <= r_s1;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_st      <= 1'b0;
          r_dc      <= '0;
          r_hc      <= '0;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
          r_long    <= 1'b0;
        end else begin
          if (r_s2 == r_st) begin
            r_dc <= '0;
          end else if (r_dc == c_DC_LAST) begin
            r_st <= r_s2;
            r_dc <= '0;
          end else begin
            r_dc <= r_dc + DC_W'(1);
          end

          r_level   <= r_st;
          r_press   <= w_rise;
          r_release <= w_fall;

          // Saturation above the fire value keeps the long pulse to one per hold
          if (!r_st || w_rise) begin
            r_hc <= '0;
          end else if (r_hc != c_HC_SAT) begin
            r_hc <= r_hc + HC_W'(1);
          end
          r_long <= r_st & ~w_rise & (r_hc == c_HC_FIRE);
        end
      end

      assign btn_level[i]   = r_level;
      assign btn_press[i]   = r_press;
      assign btn_release[i] = r_release;
      assign btn_long[i]    = r_long;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_event_decoder
//  Purpose  : Directed self-checking bench for button_event_decoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_button_event_decoder;

  localparam int NB  = 2;
  localparam int DEB = 4;
  localparam int LNG = 16;
  // Driven just after edge c, the change settles before edge c+1 and shows after c+1+2+DEB
  localparam int LAT = 1 + 2 + DEB;

  typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG, EV_RESET} ev_kind_t;
  typedef struct {
    int       cyc;
    ev_kind_t kind;
    int       ch;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = 2'b11;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_long;

  ev_t           sb[$];
  int            cyc   = 0;
  int            tests = 0;
  int            fails = 0;
  logic [NB-1:0] exp_level = '0;

  button_event_decoder #(
    .NUM_BTN        (NB),
    .ACTIVE_LOW     (1'b1),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LNG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input ev_kind_t k, input int ch);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.ch   = ch;
    sb.push_back(e);
  endtask

  // Scoreboard: retire every event due at this edge, then check all outputs
  always @(negedge clk) begin
    logic [NB-1:0] ep;
    logic [NB-1:0] er;
    logic [NB-1:0] el;
    ep = '0;
    er = '0;
    el = '0;
    if (cyc >= 1) begin
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].cyc == cyc) begin
          case (sb[k].kind)
            EV_PRESS:   begin ep[sb[k].ch] = 1'b1; exp_level[sb[k].ch] = 1'b1; end
            EV_RELEASE: begin er[sb[k].ch] = 1'b1; exp_level[sb[k].ch] = 1'b0; end
            EV_LONG:    el[sb[k].ch] = 1'b1;
            default:    exp_level = '0;
          endcase
          sb.delete(k);
        end
      end
      chk("level",   btn_level,   exp_level);
      chk("press",   btn_press,   ep);
      chk("release", btn_release, er);
      chk("long",    btn_long,    el);
    end
  end

  initial begin
    int c;
    int p;

    // Reset held for edges 1..3 with buttons released, then idle
    tick(3);
    rst = 1'b0;
    tick(50);

    // Channel 0 press, held 40 cycles past the press pulse, then released
    c = cyc;
    btn_raw[0] = 1'b0;
    push(c + LAT, EV_PRESS, 0);
    push(c + LAT + LNG, EV_LONG, 0);
    tick(LAT + 40);
    btn_raw[0] = 1'b1;
    push(cyc + LAT, EV_RELEASE, 0);
    tick(LAT + 20);

    // Bounce: 3-cycle glitches are one short of acceptance
    repeat (5) begin
      btn_raw[0] = 1'b0;
      tick(3);
      btn_raw[0] = 1'b1;
      tick(3);
    end
    tick(10);

    // Both channels pressed and released together, short of a long press
    c = cyc;
    btn_raw = 2'b00;
    push(c + LAT, EV_PRESS, 0);
    push(c + LAT, EV_PRESS, 1);
    tick(10);
    btn_raw = 2'b11;
    push(c + 10 + LAT, EV_RELEASE, 0);
    push(c + 10 + LAT, EV_RELEASE, 1);
    tick(LAT + 10);

    // Channel 1 held through a 2-cycle reset at press edge +8
    c = cyc;
    btn_raw[1] = 1'b0;
    p = c + LAT;
    push(p, EV_PRESS, 1);
    tick(LAT + 7);
    rst = 1'b1;
    push(p + 8, EV_RESET, 0);
    tick(2);
    rst = 1'b0;
    push(p + 8 + DEB + 2, EV_PRESS, 1);
    push(p + 8 + DEB + 2 + LNG, EV_LONG, 1);
    tick(DEB + 2 + LNG + 5);
    btn_raw[1] = 1'b1;
    push(cyc + LAT, EV_RELEASE, 1);
    tick(LAT + 10);

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain: observed %0d pending events expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
